// File: rtl/ysyx_25020037_axi_rd_resp_pkg.sv
// Types and helpers for the AXI read responder: FSM states and the per-beat
// response classification.
`include "ysyx_25020037_config.vh"

package ysyx_25020037_axi_rd_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_CAPT,
    ST_RESP
  } state_e;

  localparam logic [2:0] SIZE_WORD = 3'h2;

  // SLVERR (bad size/burst) wins over DECERR (beat outside the window).
  function automatic logic [1:0] beat_resp(input logic        attr_err,
                                           input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr & 32'hFFFF_FFFC} - {1'b0, base};
    if (attr_err) return `YSYX_25020037_RESP_SLVERR;
    if (off[32] || (off >= span)) return `YSYX_25020037_RESP_DECERR;
    return `YSYX_25020037_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_25020037_config.vh
// Shared AXI encodings for the read initiator and the read responder.
// Guarded so that both sides can include it within one compilation.
`ifndef YSYX_25020037_CONFIG_VH
`define YSYX_25020037_CONFIG_VH

`define YSYX_25020037_BURST_FIXED 2'b00
`define YSYX_25020037_BURST_INCR  2'b01

`define YSYX_25020037_RESP_OKAY   2'b00
`define YSYX_25020037_RESP_SLVERR 2'b10
`define YSYX_25020037_RESP_DECERR 2'b11

`endif

// File: rtl/ysyx_25020037_axi_rd_resp.sv
// AXI4 read responder (AR/R) fronting a word-addressed synchronous SRAM.
// One transaction at a time; every beat walks FETCH -> CAPT -> RESP.
`include "ysyx_25020037_config.vh"

module ysyx_25020037_axi_rd_resp
  import ysyx_25020037_axi_rd_resp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'hA000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned DELAY       = 0,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arvalid,
  output logic          arready,
  input  logic [31:0]   araddr,
  input  logic [3:0]    arid,
  input  logic [7:0]    arlen,
  input  logic [2:0]    arsize,
  input  logic [1:0]    arburst,
  output logic          rvalid,
  input  logic          rready,
  output logic [31:0]   rdata,
  output logic [1:0]    rresp,
  output logic          rlast,
  output logic [3:0]    rid,
  output logic          sram_en,
  output logic [AW-1:0] sram_addr,
  input  logic [31:0]   sram_rdata
);

  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  DLY_LAST = (DELAY == 0) ? 4'd0 : 4'(DELAY - 1);

  state_e       state_q, state_d;
  logic [3:0]   dly_q, dly_d;
  logic [7:0]   beat_q, beat_d;
  logic [7:0]   len_q, len_d;
  logic [31:0]  addr_q, addr_d;
  logic [3:0]   id_q, id_d;
  logic [2:0]   size_q, size_d;
  logic [1:0]   burst_q, burst_d;
  logic         fetch_go;
  logic [1:0]   resp_d;
  logic [AW-1:0] sram_idx;

  logic [1:0]    bresp_q;
  logic          sram_en_q;
  logic [AW-1:0] sram_addr_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic          rlast_q;
  logic [3:0]    rid_q;

  // Classification of the beat about to enter FETCH (addr_d is its address).
  assign resp_d   = beat_resp((size_d != SIZE_WORD) || burst_d[1], addr_d, ADDR_BASE, SPAN);
  assign sram_idx = AW'((addr_d - ADDR_BASE) >> 2);

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d  = state_q;
    dly_d    = dly_q;
    beat_d   = beat_q;
    len_d    = len_q;
    addr_d   = addr_q;
    id_d     = id_q;
    size_d   = size_q;
    burst_d  = burst_q;
    fetch_go = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arvalid) begin
          addr_d  = araddr;
          id_d    = arid;
          len_d   = arlen;
          size_d  = arsize;
          burst_d = arburst;
          beat_d  = '0;
          dly_d   = '0;
          if (DELAY == 0) begin
            state_d  = ST_FETCH;
            fetch_go = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dly_q == DLY_LAST) begin
          state_d  = ST_FETCH;
          fetch_go = 1'b1;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      ST_FETCH: state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_RESP;
      ST_RESP: begin
        if (rready) begin
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
          end else begin
            beat_d   = beat_q + 8'd1;
            // FIXED repeats the same address; INCR wraps at 32 bits.
            if (burst_q == `YSYX_25020037_BURST_INCR) addr_d = addr_q + 32'd4;
            state_d  = ST_FETCH;
            fetch_go = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      dly_q       <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      bresp_q     <= '0;
      sram_en_q   <= 1'b0;
      sram_addr_q <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rlast_q     <= 1'b0;
      rid_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      dly_q     <= dly_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      sram_en_q <= fetch_go && (resp_d == `YSYX_25020037_RESP_OKAY);
      if (fetch_go) begin
        bresp_q <= resp_d;
        if (resp_d == `YSYX_25020037_RESP_OKAY) sram_addr_q <= sram_idx;
      end
      // Erroring beats never touched the SRAM, so their data is forced to zero.
      if (state_q == ST_CAPT) begin
        rdata_q <= (bresp_q == `YSYX_25020037_RESP_OKAY) ? sram_rdata : 32'd0;
        rresp_q <= bresp_q;
        rlast_q <= (beat_q == len_q);
        rid_q   <= id_q;
      end
    end
  end

  assign arready   = (state_q == ST_IDLE);
  assign rvalid    = (state_q == ST_RESP);
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign rlast     = rlast_q;
  assign rid       = rid_q;
  assign sram_en   = sram_en_q;
  assign sram_addr = sram_addr_q;

endmodule

// File: doc/ysyx_25020037_axi_rd_resp.md
# ysyx_25020037_axi_rd_resp

AXI4 read-channel responder (AR/R) that serves single-beat and burst read requests from a fetch or load initiator. It fronts a word-addressed synchronous SRAM. It sits on the slave side of the crossbar, opposite the instruction-fetch unit's read initiator, and returns `rlast`-terminated bursts with per-beat response codes.

## Interface
- `ADDR_BASE`, 32'hA000_0000, byte address of word 0
- `DEPTH_WORDS`, 1024, number of 32-bit words served; power of two
- `DELAY`, 0, extra wait cycles inserted between AR acceptance and the first SRAM access (0..15)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous reset, active-low
- `arvalid`  in  1  address valid
- `arready`  out  1  address accepted
- `araddr`  in  32  byte address of first beat
- `arid`  in  4  transaction ID
- `arlen`  in  8  beats minus one
- `arsize`  in  3  beat size; only 3'h2 is legal
- `arburst`  in  2  0 FIXED, 1 INCR; 2 and 3 are illegal
- `rvalid`  out  1  read beat valid
- `rready`  in  1  initiator accepts beat
- `rdata`  out  32  beat data
- `rresp`  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- `rlast`  out  1  final beat of burst
- `rid`  out  4  echoes captured `arid`
- `sram_en`  out  1  SRAM read strobe
- `sram_addr`  out  $clog2(DEPTH_WORDS)  word index
- `sram_rdata`  in  32  valid exactly one cycle after `sram_en`

## Operation
- States:
  - IDLE: `arready`=1.
  - WAIT: counts `DELAY` cycles.
  - FETCH: `sram_en` pulses for one cycle.
  - CAPT: latches `sram_rdata` into `rdata`.
  - RESP: holds `rvalid` until `rready`.
- IDLE -> WAIT on `arvalid & arready`, or directly to FETCH if `DELAY`==0. The handshake captures `araddr`, `arid`, `arlen`, `arsize`, `arburst`, and clears the beat counter.
- WAIT -> FETCH when the delay counter reaches `DELAY`-1.
- FETCH -> CAPT -> RESP.
- RESP on `rvalid & rready`:
  - If the beat is the last one: go to IDLE.
  - Otherwise: increment the beat counter, update the address, and go to FETCH. There is no re-delay between beats.
- Address update:
  - INCR: `addr + 4`, 32-bit wrap.
  - FIXED: address unchanged.
- `rlast` = (beat counter == captured `arlen`).
- Per-beat error checks. Each failing beat skips the SRAM access (`sram_en` stays 0) and still takes one cycle in FETCH and CAPT; it returns `rdata`=0.
  - `arsize`≠2, or `arburst`≥2: SLVERR on every beat.
  - Beat address outside [`ADDR_BASE`, `ADDR_BASE`+4·`DEPTH_WORDS`): DECERR for that beat.
  - SLVERR takes precedence over DECERR.
- Address bits [1:0] are ignored. `sram_addr` = (addr − `ADDR_BASE`) >> 2.
- One transaction is outstanding at a time; `arready`=0 outside IDLE.

## Timing
- `arready` is combinational from state: 1 in IDLE only.
- With `DELAY`=0 and handshake at edge 0:
  - `sram_en` is high in cycle 1.
  - `rvalid` is high from cycle 3.
  - Next-beat `sram_en` is in the cycle after the R handshake.
- Sustained throughput is one beat per 3 cycles when `rready` is held high.
- First-beat latency is `DELAY`+3 cycles from the AR handshake.
- `rdata`, `rresp`, `rlast`, and `rid` are registered and stable while `rvalid`=1 and `rready`=0.
- An AR arriving while busy is not accepted. The initiator must hold `arvalid`.
- Reset is asynchronous: state goes to IDLE, an in-flight burst is abandoned with no further beats, and these outputs go to 0: `rvalid`, `rdata`, `rresp`, `rlast`, `rid`, `sram_en`, `sram_addr`.
- After reset deassertion, `arready`=1 in the first cycle.

## Structure
- Add burst encodings (FIXED/INCR) and response codes (OKAY/SLVERR/DECERR) as macros in `ysyx_25020037_config.vh`. The initiator already includes this header, so both sides share one definition.
- The FSM, delay counter, beat counter, and address generator are inline; there are no sub-modules in the RTL.
- The SRAM is external. The bench provides `ysyx_25020037_sram_model` with a 1-cycle read latency.

## Test plan
- Single beat, `DELAY`=0: `araddr`=A000_0010, `arlen`=0, `arburst`=0, mem[4]=DEADBEEF -> one beat with `rdata`=DEADBEEF, OKAY, `rlast`=1, `rid`=`arid`, `rvalid` high 3 cycles after the handshake.
- INCR burst: `araddr`=A000_0000, `arlen`=3, `rready` always 1 -> mem[0..3] in order, `rlast` only on the 4th beat, beats 3 cycles apart, `arready` back to 1 after the last beat.
- Backpressure: `rready` held 0 for 5 cycles on beat 2 of a 4-beat INCR -> `rvalid`, `rdata`, and `rlast`=0 stay stable, and there is no extra `sram_en`.
- Errors:
  - `arsize`=1, `arlen`=1 -> two SLVERR beats with `rdata`=0.
  - INCR from A000_0FFC with `DEPTH_WORDS`=1024, `arlen`=1 -> beat 1 OKAY, beat 2 DECERR with no `sram_en`.
- FIXED plus delay: `DELAY`=4, FIXED `arlen`=2 at A000_0008 -> three beats of mem[2], and the first `sram_en` comes 5 cycles after the handshake.
- Reset mid-burst: assert `rst`=0 during beat 2 of 4 -> `rvalid` drops immediately. After release, `arready`=1 and a new single read completes correctly.
